// File: rtl/datamem_arbiter_if.sv
// Request/response bundle between one datamem master and the arbiter.
// Handshake: the master raises req with we/addr/wdata stable and holds all of them until
// ack; ack is a one-cycle pulse, and rdata/err are meaningful only while ack is high.
interface datamem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/datamem_arbiter.sv
// Round-robin two-master arbiter for the single-port datamem: latch one transaction,
// issue exactly one memory cycle, then acknowledge the granted master.
module datamem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 2048
) (
  input  logic                  clk,
  input  logic                  nrst,
  datamem_arbiter_if.slave      m0,
  datamem_arbiter_if.slave      m1,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_BYTES - 4);

  state_t state, state_next;

  logic                  last_grant;
  logic                  grant_valid;
  logic                  grant_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_ok;

  logic                  lat_id;
  logic                  lat_we;
  logic                  lat_ok;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;

  // On a tie the master that did not win last time is granted.
  always_comb begin
    grant_valid = m0.req | m1.req;
    grant_id    = (m0.req && m1.req) ? ~last_grant : m1.req;
    sel_we      = grant_id ? m1.we    : m0.we;
    sel_addr    = grant_id ? m1.addr  : m0.addr;
    sel_wdata   = grant_id ? m1.wdata : m0.wdata;
    sel_ok      = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_ok     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE && grant_valid) begin
        last_grant <= grant_id;
        lat_id     <= grant_id;
        lat_we     <= sel_we;
        lat_ok     <= sel_ok;
        lat_addr   <= sel_addr;
        lat_wdata  <= sel_wdata;
        rdata_q    <= '0;
      end
      // Writes and rejected accesses hand back zero read data.
      if (state == ACCESS) begin
        rdata_q <= (lat_ok && !lat_we) ? data_out : '0;
      end
    end
  end

  always_comb begin
    data_addr = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    data_in   = '0;
    m0.ack    = 1'b0;
    m0.err    = 1'b0;
    m0.rdata  = '0;
    m1.ack    = 1'b0;
    m1.err    = 1'b0;
    m1.rdata  = '0;
    if (state == ACCESS && lat_ok) begin
      data_addr = lat_addr;
      mem_write = lat_we;
      mem_read  = ~lat_we;
      data_in   = lat_we ? lat_wdata : '0;
    end
    if (state == RESP) begin
      if (lat_id) begin
        m1.ack   = 1'b1;
        m1.err   = ~lat_ok;
        m1.rdata = rdata_q;
      end else begin
        m0.ack   = 1'b1;
        m0.err   = ~lat_ok;
        m0.rdata = rdata_q;
      end
    end
  end

  assign fsm_state = state;

endmodule
